// File: rtl/mode7_raster_scan.sv
// mode7_raster_scan: VGA raster timing generator for the Mode7 mapper.
// Drives screen (x, y) to the mapper and aligns its colour with sync/blank through
// a PIPE_LAT-stage pipeline onto RGB332 DAC pins. The per-frame transform parameters
// are shadowed and only reload at the start of vertical blank.
module mode7_raster_scan #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [7:0]  color_in,
  input  logic [9:0]  angle_in,
  input  logic [23:0] scalex_in,
  input  logic [23:0] scaley_in,
  input  logic [15:0] originx_in,
  input  logic [15:0] originy_in,
  input  logic [15:0] offsetx_in,
  input  logic [15:0] offsety_in,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [9:0]  angle,
  output logic [23:0] scalex,
  output logic [23:0] scaley,
  output logic [15:0] originx,
  output logic [15:0] originy,
  output logic [15:0] offsetx,
  output logic [15:0] offsety,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        frame_start
);

  localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(H_TOT);
  localparam int unsigned VW     = $clog2(V_TOT);
  localparam int unsigned H_SS   = H_VIS + H_FP;
  localparam int unsigned H_SE   = H_SS + H_SYNC;
  localparam int unsigned V_SS   = V_VIS + V_FP;
  localparam int unsigned V_SE   = V_SS + V_SYNC;
  localparam int unsigned LAST   = PIPE_LAT - 1;
  localparam logic [23:0] ONE_88 = 24'h000100;

  // Colour is blanked before entering the pipeline, so no separate active bit is carried.
  typedef struct packed {
    logic [7:0] color;
    logic       hs_n;
    logic       vs_n;
  } pix_t;

  localparam pix_t PIX_IDLE = '{color: 8'd0, hs_n: 1'b1, vs_n: 1'b1};

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_last;
  logic          v_last;
  logic          shadow_load;
  pix_t          raw;
  pix_t          pipe [PIPE_LAT];

  // Raw timing decode at the current counter position
  always_comb begin
    raw       = PIX_IDLE;
    raw.color = (h < HW'(H_VIS) && v < VW'(V_VIS)) ? color_in : 8'd0;
    raw.hs_n  = !(h >= HW'(H_SS) && h < HW'(H_SE));
    raw.vs_n  = !(v >= VW'(V_SS) && v < VW'(V_SE));
  end

  assign h_last      = (h == HW'(H_TOT - 1));
  assign v_last      = (v == VW'(V_TOT - 1));
  assign shadow_load = (h == '0) && (v == VW'(V_VIS));

  // Counters, alignment pipeline, parameter shadows and frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      frame_start <= 1'b0;
      for (int i = 0; i < int'(PIPE_LAT); i++) pipe[i] <= PIX_IDLE;
      angle       <= 10'd0;
      scalex      <= ONE_88;
      scaley      <= ONE_88;
      originx     <= 16'd0;
      originy     <= 16'd0;
      offsetx     <= 16'd0;
      offsety     <= 16'd0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        frame_start <= h_last && v_last;
        pipe[0]     <= raw;
        for (int i = 1; i < int'(PIPE_LAT); i++) pipe[i] <= pipe[i-1];
        if (shadow_load) begin
          angle   <= angle_in;
          scalex  <= scalex_in;
          scaley  <= scaley_in;
          originx <= originx_in;
          originy <= originy_in;
          offsetx <= offsetx_in;
          offsety <= offsety_in;
        end
        if (h_last) begin
          h <= '0;
          v <= v_last ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  assign x     = 16'(h);
  assign y     = 16'(v);
  assign hsync = pipe[LAST].hs_n;
  assign vsync = pipe[LAST].vs_n;
  assign vga_r = pipe[LAST].color[7:5];
  assign vga_g = pipe[LAST].color[4:2];
  assign vga_b = pipe[LAST].color[1:0];

endmodule
